// File: rtl/mem_line_responder.sv
// Line-granular memory responder: accepts one read request at a time and returns a
// 128-bit line a fixed number of cycles later, holding it until the requester lets go.
module mem_line_responder #(
    parameter int LINES   = 256,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  mem_bus_address,
    input  logic         mem_read_start,
    output logic [127:0] mem_bus_data,
    output logic         mem_read_rdy,
    input  logic         wr_en,
    input  logic [31:0]  wr_addr,
    input  logic [127:0] wr_data,
    output logic         busy
);

    localparam int         IDX_W    = $clog2(LINES);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        READY   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [3:0]         count_reg;
    logic [IDX_W-1:0]   addr_reg;
    logic [127:0]       data_reg;
    logic               rdy_reg;
    logic               busy_reg;
    logic [127:0]       mem_reg [LINES];

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               unused_addr_bits;

    assign req_idx = mem_bus_address[IDX_W+3:4];
    assign wr_idx  = wr_addr[IDX_W+3:4];

    // Upper address bits alias onto the same lines; byte offset is irrelevant.
    assign unused_addr_bits = ^{mem_bus_address[31:IDX_W+4], mem_bus_address[3:0],
                                wr_addr[31:IDX_W+4], wr_addr[3:0]};

    // Storage is cleared on reset, so it is built from resettable registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINES; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            rdy_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_read_start) begin
                        addr_reg <= req_idx;
                        busy_reg <= 1'b1;
                        if (LATENCY == 1) begin
                            state_reg <= READY;
                            count_reg <= '0;
                            data_reg  <= mem_reg[req_idx];
                            rdy_reg   <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                            count_reg <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_read_start) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                    end else if (count_reg <= 4'd1) begin
                        // Nonblocking read: a same-edge write is not seen here.
                        state_reg <= READY;
                        count_reg <= '0;
                        data_reg  <= mem_reg[addr_reg];
                        rdy_reg   <= 1'b1;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                READY: begin
                    if (!mem_read_start) begin
                        state_reg <= RELEASE;
                        data_reg  <= '0;
                        rdy_reg   <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    data_reg  <= '0;
                    rdy_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_bus_data = data_reg;
    assign mem_read_rdy = rdy_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed scenarios plus randomized reads/writes checked
// against a plain array model of the line store.
module tb_mem_line_responder;

    localparam int LINES   = 256;
    localparam int LATENCY = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  mem_bus_address = '0;
    logic         mem_read_start = 1'b0;
    logic [127:0] mem_bus_data;
    logic         mem_read_rdy;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [127:0] wr_data = '0;
    logic         busy;

    always #5 clk = ~clk;

    mem_line_responder #(
        .LINES  (LINES),
        .LATENCY(LATENCY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_bus_address(mem_bus_address),
        .mem_read_start (mem_read_start),
        .mem_bus_data   (mem_bus_data),
        .mem_read_rdy   (mem_read_rdy),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy)
    );

    logic [127:0] model_mem [LINES];
    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] D_A   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D_B   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] ONES  = {128{1'b1}};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [127:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        model_mem[line_of(addr)] = data;
    endtask

    // Full read: accept, wait out the latency, hold, release, return to idle.
    // The accepting edge counts as the first of the LATENCY edges.
    task automatic do_read(input logic [31:0] addr, input int hold, input bit wander,
                           input bit scribble);
        logic [127:0] exp;
        int n;
        exp = model_mem[line_of(addr)];
        mem_bus_address = addr;
        mem_read_start  = 1'b1;
        step();
        chk("busy_accept", busy, 1'b1);
        if (wander) mem_bus_address = $urandom();
        n = 0;
        while (mem_read_rdy !== 1'b1 && n < 20) begin
            chk("data_zero_wait", mem_bus_data, '0);
            step();
            n++;
        end
        chk("latency", n, LATENCY - 1);
        chk("read_data", mem_bus_data, exp);
        for (int i = 0; i < hold; i++) begin
            if (scribble) begin
                wr_en   = 1'b1;
                wr_addr = addr;
                wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            step();
            if (scribble) begin
                model_mem[line_of(addr)] = wr_data;
                wr_en = 1'b0;
            end
            chk("hold_rdy", mem_read_rdy, 1'b1);
            chk("hold_data", mem_bus_data, exp);
        end
        mem_read_start = 1'b0;
        step();
        chk("release_rdy", mem_read_rdy, 1'b0);
        chk("release_data", mem_bus_data, '0);
        chk("release_busy", busy, 1'b1);
        step();
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        for (int i = 0; i < LINES; i++) model_mem[i] = '0;

        // Reset state, observed while reset is held
        #3;
        chk("reset_rdy", mem_read_rdy, 1'b0);
        chk("reset_data", mem_bus_data, '0);
        chk("reset_busy", busy, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_reset_busy", busy, 1'b0);

        // Basic read with aliasing offset and a 10-cycle hold; address wanders after accept
        do_write(32'h0000_0020, D_A);
        do_read(32'h0000_002C, 10, 1'b1, 1'b0);

        // Abort two cycles into WAIT
        mem_bus_address = 32'h0000_0020;
        mem_read_start  = 1'b1;
        step();
        chk("abort_busy_accept", busy, 1'b1);
        step();
        chk("abort_wait_rdy1", mem_read_rdy, 1'b0);
        step();
        chk("abort_wait_rdy2", mem_read_rdy, 1'b0);
        mem_read_start = 1'b0;
        step();
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdy", mem_read_rdy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_rdy", mem_read_rdy, 1'b0);
        end

        // A start raised in RELEASE is only accepted once back in IDLE
        mem_bus_address = 32'h0000_0020;
        mem_read_start  = 1'b1;
        for (int i = 0; i < 20 && mem_read_rdy !== 1'b1; i++) step();
        chk("rr_first_rdy", mem_read_rdy, 1'b1);
        mem_read_start = 1'b0;
        step();
        chk("rr_release_rdy", mem_read_rdy, 1'b0);
        mem_read_start = 1'b1;
        step();
        chk("rr_idle_busy", busy, 1'b0);
        step();
        chk("rr_accept_busy", busy, 1'b1);
        for (int i = 0; i < LATENCY - 2; i++) begin
            step();
            chk("rr_wait_rdy", mem_read_rdy, 1'b0);
        end
        step();
        chk("rr_rdy", mem_read_rdy, 1'b1);
        chk("rr_data", mem_bus_data, D_A);
        mem_read_start = 1'b0;
        step();
        step();

        // High address bits alias onto line 0x10
        do_write(32'h0000_0010, D_B);
        do_read(32'h0000_1010, 2, 1'b0, 1'b0);

        // Write to the target line on the READY-entry edge: old contents are returned
        mem_bus_address = 32'h0000_0020;
        mem_read_start  = 1'b1;
        step();
        for (int i = 0; i < LATENCY - 2; i++) step();
        wr_en   = 1'b1;
        wr_addr = 32'h0000_0020;
        wr_data = ONES;
        step();
        wr_en = 1'b0;
        model_mem[line_of(32'h20)] = ONES;
        chk("collide_rdy", mem_read_rdy, 1'b1);
        chk("collide_data", mem_bus_data, D_A);
        mem_read_start = 1'b0;
        step();
        step();
        do_read(32'h0000_0020, 1, 1'b0, 1'b0);

        // Randomized traffic against the array model
        for (int i = 0; i < 40; i++) begin
            do_write($urandom(), {$urandom(), $urandom(), $urandom(), $urandom()});
        end
        for (int i = 0; i < 25; i++) begin
            ra = (i % 3 == 0) ? 32'h0000_0020 : $urandom();
            do_read(ra, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        // Reset while in READY clears the output at once
        do_write(32'h0000_0040, D_B);
        mem_bus_address = 32'h0000_0040;
        mem_read_start  = 1'b1;
        for (int i = 0; i < 20 && mem_read_rdy !== 1'b1; i++) step();
        chk("rst_ready_pre", mem_bus_data, D_B);
        reset = 1'b0;
        #1;
        chk("rst_ready_rdy", mem_read_rdy, 1'b0);
        chk("rst_ready_data", mem_bus_data, '0);
        chk("rst_ready_busy", busy, 1'b0);
        mem_read_start = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < LINES; i++) model_mem[i] = '0;
        step();

        // Reset during WAIT: transaction abandoned, storage cleared
        do_write(32'h0000_0020, D_A);
        do_write(32'h0000_0010, D_B);
        mem_bus_address = 32'h0000_0020;
        mem_read_start  = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_wait_rdy", mem_read_rdy, 1'b0);
        chk("rst_wait_data", mem_bus_data, '0);
        chk("rst_wait_busy", busy, 1'b0);
        mem_read_start = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < LINES; i++) model_mem[i] = '0;
        for (int i = 0; i < LATENCY + 3; i++) begin
            step();
            chk("rst_no_rdy", mem_read_rdy, 1'b0);
        end
        do_read(32'h0000_0020, 0, 1'b0, 1'b0);
        do_read(32'h0000_0010, 0, 1'b0, 1'b0);
        do_read(32'h0000_0040, 0, 1'b0, 1'b0);
        chk("rst_line20_zero", model_mem[line_of(32'h20)], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter LINES, default 256, meaning number of 128-bit lines stored (power of two, 2..4096).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from accepted request to mem_read_rdy (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_bus_address  input  32  line request address; bits [3:0] ignored.
REQ-006 SHALL have port mem_read_start  input  1  request from the cache, held high until the transaction ends.
REQ-007 SHALL have port mem_bus_data  output  128  returned line; byte at offset 0 in [127:120], offset 15 in [7:0].
REQ-008 SHALL have port mem_read_rdy  output  1  line valid on mem_bus_data.
REQ-009 SHALL have port wr_en  input  1  single-cycle line write strobe (preload/bench port).
REQ-010 SHALL have port wr_addr  input  32  write line address; bits [3:0] ignored.
REQ-011 SHALL have port wr_data  input  128  line written, same byte order as mem_bus_data.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL index storage with address bits [log2(LINES)+3:4]; higher bits ignored (aliasing, no error).
REQ-014 SHALL implement FSM states IDLE, WAIT, READY, RELEASE.
REQ-015 IDLE: on edge with mem_read_start=1, SHALL latch mem_bus_address, load counter with LATENCY-1, go to WAIT (LATENCY=1: go directly to READY).
REQ-016 WAIT: SHALL decrement counter each edge; at edge where counter=1 (or 0 on entry) SHALL go to READY.
REQ-017 Entering READY SHALL capture the latched line into an output register and assert mem_read_rdy; mem_read_rdy thus rises exactly LATENCY edges after the accepting edge.
REQ-018 READY: mem_bus_data and mem_read_rdy SHALL stay stable while mem_read_start=1.
REQ-019 READY: on edge with mem_read_start=0, SHALL deassert mem_read_rdy and go to RELEASE.
REQ-020 RELEASE: SHALL go to IDLE next edge unconditionally; a start seen in RELEASE is not accepted until IDLE.
REQ-021 mem_bus_data SHALL be 128'b0 whenever mem_read_rdy=0.
REQ-022 WAIT with mem_read_start=0 (abort) SHALL return to IDLE next edge without asserting mem_read_rdy.
REQ-023 wr_en=1 SHALL write wr_data to line wr_addr at that edge, in any FSM state.
REQ-024 Write to the line being captured on the same edge as READY entry: response SHALL carry the pre-write contents.
REQ-025 Write to a line already captured in READY SHALL not change mem_bus_data.
REQ-026 Only one transaction SHALL be outstanding; mem_bus_address changes after acceptance SHALL be ignored.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, mem_read_rdy=0, mem_bus_data=0, busy=0, counter=0.
REQ-028 Reset SHALL clear all storage lines to 128'b0.
REQ-029 Reset mid-transaction SHALL abandon it; no mem_read_rdy after release until a new start is accepted.

Verification
REQ-030 Write line 0x00000020 = 0x00112233_44556677_8899AABB_CCDDEEFF, start at 0x0000002C, LATENCY=4 -> mem_read_rdy high 4 edges after accept, mem_bus_data equals written value.
REQ-031 Hold start 10 cycles after rdy -> rdy/data stable; drop start -> rdy low next edge, busy low one edge later.
REQ-032 Drop start two cycles into WAIT -> rdy never asserts, IDLE next edge, busy=0.
REQ-033 Read 0x00001010 with LINES=256 -> returns line 0x00000010 (aliasing).
REQ-034 wr_en to target line on the READY-entry edge, new data 0xFFFF...F -> response carries old data; next read returns 0xFFFF...F.
REQ-035 Assert reset=0 during WAIT -> rdy=0, data=0 immediately; all lines read back 0 after release.
